generator_jedynek: RTL and testbench

- Inverse of the ALU ones-counter: takes a count N and builds a BITS-wide word containing exactly N ones, packed at the LSB end as a thermometer code.
- Sequential: fills one bit per clock under a start/valid handshake.
- Sits beside the ALU counting ops as the "build mask from count" operation.
- Saturates and flags an error when N exceeds BITS.

---
 rtl/alu_pkg.sv | 15 +
 rtl/generator_jedynek_if.sv | 34 +++
 rtl/generator_jedynek_licz_jedynki.sv | 19 +
 rtl/generator_jedynek.sv | 109 ++++++++++
 tb/tb_generator_jedynek.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU counting-op definitions: generator FSM states and the count-width helper.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    // Width needed to hold any count 0..bits inclusive.
    function automatic int cw_of(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/generator_jedynek_if.sv
// Request/response bundle for the ones generator.
// o_mismatch exists only when GENERATOR_JEDYNEK_CHECK_EN is defined.
interface generator_jedynek_if #(
    parameter int BITS = 8
) ();
    localparam int CW = alu_pkg::cw_of(BITS);

    logic            i_start;
    logic [CW-1:0]   i_count;
    logic [BITS-1:0] o_result;
    logic            o_busy;
    logic            o_valid;
    logic            o_error;
`ifdef GENERATOR_JEDYNEK_CHECK_EN
    logic            o_mismatch;
`endif

    modport master (
        output i_start, i_count,
`ifdef GENERATOR_JEDYNEK_CHECK_EN
        input  o_mismatch,
`endif
        input  o_result, o_busy, o_valid, o_error
    );

    modport slave (
        input  i_start, i_count,
`ifdef GENERATOR_JEDYNEK_CHECK_EN
        output o_mismatch,
`endif
        output o_result, o_busy, o_valid, o_error
    );

endinterface

// File: rtl/generator_jedynek_licz_jedynki.sv
// Combinational popcount; also usable by the ALU count operation.
module licz_jedynki
    import alu_pkg::*;
#(
    parameter int BITS = 8,
    parameter int CW   = cw_of(BITS)
) (
    input  logic [BITS-1:0] word,
    output logic [CW-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < BITS; i++) begin
            count = count + CW'(word[i]);
        end
    end

endmodule

// File: rtl/generator_jedynek.sv
// Builds a BITS-wide thermometer word with N ones, one bit per clock.
// Optional self-check (o_mismatch + thermometer assertion): GENERATOR_JEDYNEK_CHECK_EN.
module generator_jedynek
    import alu_pkg::*;
#(
    parameter int BITS = 8
) (
    input logic               i_clk,
    input logic               i_rsn,
    generator_jedynek_if.slave bus
);

    localparam int              CW     = cw_of(BITS);
    localparam logic [CW-1:0]   BITS_C = CW'(BITS);

    gen_state_t      state, state_nx;
    logic [CW-1:0]   remaining;
    logic [CW-1:0]   cnt_sat;
    logic            over;
    logic [BITS-1:0] result;
    logic            error;

    // Requests above BITS saturate to a full word and raise the error flag.
    assign over    = (bus.i_count > BITS_C);
    assign cnt_sat = over ? BITS_C : bus.i_count;

    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_nx = (cnt_sat == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (remaining == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            result    <= '0;
            error     <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        result    <= '0;
                        error     <= over;
                        remaining <= cnt_sat;
                    end
                end
                FILL: begin
                    result    <= {result[BITS-2:0], 1'b1};
                    remaining <= remaining - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_result = result;
    assign bus.o_busy   = (state == FILL);
    assign bus.o_valid  = (state == DONE);
    assign bus.o_error  = error;

`ifdef GENERATOR_JEDYNEK_CHECK_EN
    logic [CW-1:0] cnt_lat;
    logic [CW-1:0] pop;

    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            cnt_lat <= '0;
        end else if (state == IDLE && bus.i_start) begin
            cnt_lat <= cnt_sat;
        end
    end

    // Popcount looks at the port value so a disturbed output is caught.
    licz_jedynki #(.BITS(BITS), .CW(CW)) u_licz (
        .word  (bus.o_result),
        .count (pop)
    );

    assign bus.o_mismatch = (state == DONE) && (pop != cnt_lat);

    always_ff @(posedge i_clk) begin
        if (i_rsn) begin
            assert ((bus.o_result & (bus.o_result + BITS'(1))) == '0)
                else $error("o_result not a thermometer code: %h", bus.o_result);
        end
    end
`endif

endmodule

// File: tb/tb_generator_jedynek.sv
// Directed bench for generator_jedynek (BITS=8); check-feature test under GENERATOR_JEDYNEK_CHECK_EN.
module tb_generator_jedynek;

    logic clk = 1'b0;
    logic rsn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    generator_jedynek_if #(.BITS(8)) bus ();

    generator_jedynek #(.BITS(8)) dut (
        .i_clk (clk),
        .i_rsn (rsn),
        .bus   (bus)
    );

    // Issue one request and observe 20 cycles after acceptance.
    task automatic do_req(input logic [3:0] c, input int repulse_at, input int rst_at,
                          output int busy_n, output int valid_at, output int valid_n,
                          output logic [7:0] res, output logic err, output logic mism,
                          output logic [7:0] final_res);
        busy_n = 0; valid_at = -1; valid_n = 0; res = '0; err = 1'b0; mism = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_count = c;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_count = 4'hF ^ c;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (bus.o_busy) busy_n++;
            if (bus.o_valid) begin
                valid_n++;
                if (valid_at < 0) begin
                    valid_at = cyc;
                    res      = bus.o_result;
                    err      = bus.o_error;
`ifdef GENERATOR_JEDYNEK_CHECK_EN
                    mism     = bus.o_mismatch;
`endif
                end
            end
            bus.i_start = (cyc == repulse_at);
            rsn         = (cyc != rst_at);
        end
        final_res = bus.o_result;
    endtask

    task automatic test_reset();
        bus.i_start = 1'b1;
        bus.i_count = 4'd5;
        rsn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        rsn = 1'b1;
        @(negedge clk);
        checks++; if (bus.o_result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", bus.o_result); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
        checks++; if (bus.o_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.o_error); end
    endtask

    task automatic test_nominal();
        int b, va, vn; logic [7:0] r, fr; logic e, m;
        do_req(4'd3, 0, 0, b, va, vn, r, e, m, fr);
        checks++; if (b != 3) begin errors++; $display("FAIL nom_busy got %0d want 3", b); end
        checks++; if (va != 4) begin errors++; $display("FAIL nom_latency got %0d want 4", va); end
        checks++; if (vn != 1) begin errors++; $display("FAIL nom_valid_count got %0d want 1", vn); end
        checks++; if (r !== 8'h07) begin errors++; $display("FAIL nom_result got %h want 07", r); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL nom_error got %b want 0", e); end
        checks++; if (fr !== 8'h07) begin errors++; $display("FAIL nom_hold got %h want 07", fr); end
    endtask

    task automatic test_zero_full();
        int b, va, vn; logic [7:0] r, fr; logic e, m;
        do_req(4'd0, 0, 0, b, va, vn, r, e, m, fr);
        checks++; if (va != 1) begin errors++; $display("FAIL zero_latency got %0d want 1", va); end
        checks++; if (b != 0) begin errors++; $display("FAIL zero_busy got %0d want 0", b); end
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL zero_result got %h want 00", r); end
        do_req(4'd8, 0, 0, b, va, vn, r, e, m, fr);
        checks++; if (va != 9) begin errors++; $display("FAIL full_latency got %0d want 9", va); end
        checks++; if (b != 8) begin errors++; $display("FAIL full_busy got %0d want 8", b); end
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL full_result got %h want FF", r); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL full_error got %b want 0", e); end
    endtask

    task automatic test_overflow();
        int b, va, vn; logic [7:0] r, fr; logic e, m;
        do_req(4'd12, 0, 0, b, va, vn, r, e, m, fr);
        checks++; if (va != 9) begin errors++; $display("FAIL ovf_latency got %0d want 9", va); end
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL ovf_result got %h want FF", r); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ovf_error got %b want 1", e); end
        checks++; if (bus.o_error !== 1'b1) begin errors++; $display("FAIL ovf_error_hold got %b want 1", bus.o_error); end
        do_req(4'd2, 0, 0, b, va, vn, r, e, m, fr);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", e); end
        checks++; if (r !== 8'h03) begin errors++; $display("FAIL ovf_next_result got %h want 03", r); end
        checks++; if (va != 3) begin errors++; $display("FAIL ovf_next_latency got %0d want 3", va); end
    endtask

    task automatic test_busy_ignore();
        int b, va, vn; logic [7:0] r, fr; logic e, m;
        do_req(4'd5, 2, 0, b, va, vn, r, e, m, fr);
        checks++; if (vn != 1) begin errors++; $display("FAIL busy_valid_count got %0d want 1", vn); end
        checks++; if (va != 6) begin errors++; $display("FAIL busy_latency got %0d want 6", va); end
        checks++; if (r !== 8'h1F) begin errors++; $display("FAIL busy_result got %h want 1F", r); end
        checks++; if (b != 5) begin errors++; $display("FAIL busy_cycles got %0d want 5", b); end
    endtask

    task automatic test_mid_reset();
        int b, va, vn; logic [7:0] r, fr; logic e, m;
        do_req(4'd6, 0, 3, b, va, vn, r, e, m, fr);
        checks++; if (vn != 0) begin errors++; $display("FAIL mrst_valid_count got %0d want 0", vn); end
        checks++; if (fr !== 8'h00) begin errors++; $display("FAIL mrst_result got %h want 00", fr); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_error !== 1'b0) begin errors++; $display("FAIL mrst_error got %b want 0", bus.o_error); end
    endtask

    task automatic test_back_to_back();
        int v[$];
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_count = 4'd2;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (bus.o_valid) v.push_back(cyc);
        end
        bus.i_start = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (v.size() != 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", v.size()); end
        if (v.size() == 3) begin
            checks++; if (v[0] != 3) begin errors++; $display("FAIL b2b_first got %0d want 3", v[0]); end
            checks++; if (v[1] != 7) begin errors++; $display("FAIL b2b_second got %0d want 7", v[1]); end
            checks++; if (v[2] != 11) begin errors++; $display("FAIL b2b_third got %0d want 11", v[2]); end
        end
    endtask

`ifdef GENERATOR_JEDYNEK_CHECK_EN
    task automatic test_check();
        int b, va, vn; logic [7:0] r, fr, exp_r; logic e, m;
        for (int c = 0; c <= 8; c++) begin
            exp_r = 8'((16'd1 << c) - 16'd1);
            do_req(4'(c), 0, 0, b, va, vn, r, e, m, fr);
            checks++; if (m !== 1'b0) begin errors++; $display("FAIL chk_mismatch_%0d got %b want 0", c, m); end
            checks++; if (r !== exp_r) begin errors++; $display("FAIL chk_result_%0d got %h want %h", c, r, exp_r); end
        end
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_count = 4'd3;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        force bus.o_result = 8'h0F;
        @(negedge clk);
        checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL chk_force_valid got %b want 1", bus.o_valid); end
        checks++; if (bus.o_mismatch !== 1'b1) begin errors++; $display("FAIL chk_force_mismatch got %b want 1", bus.o_mismatch); end
        release bus.o_result;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        bus.i_start = 1'b0;
        bus.i_count = '0;
        test_reset();
        test_nominal();
        test_zero_full();
        test_overflow();
        test_busy_ignore();
        test_mid_reset();
        test_back_to_back();
`ifdef GENERATOR_JEDYNEK_CHECK_EN
        test_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
